dq_rx_align: RTL

DQ_RX_ALIGN -- requirements
Module: dq_rx_align

---
 rtl/dq_rx_pkg.sv | 20 ++
 rtl/dq_rx_align.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dq_rx_pkg.sv
// -----------------------------------------------------------------------------
// dq_rx_pkg
// Shared types for the DQ receive word-alignment block.
//   DQ_W           : deserialized word width (8 bits, 1:8 DDR deserializer)
//   align_state_e  : calibration FSM states
// -----------------------------------------------------------------------------
package dq_rx_pkg;

  localparam int DQ_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    CHECK   = 3'd2,
    SLIP    = 3'd3,
    ALIGNED = 3'd4,
    FAIL    = 3'd5
  } align_state_e;

endpackage

// File: rtl/dq_rx_align.sv
// -----------------------------------------------------------------------------
// dq_rx_align
// Word-alignment calibration for a 1:8 DDR deserializer. After a start pulse
// the block waits for the deserializer output to settle, then compares each
// received word against TRAIN_PATTERN. A mismatch requests one bitslip and
// restarts the settle/compare sequence; MATCH_COUNT consecutive matches declare
// alignment. If the word still mismatches after 7 slips (all 8 positions
// tried) the block reports failure.
//
// Optional feature (macro DQ_RX_ALIGN_ERRMON_EN): once aligned, every received
// word that differs from TRAIN_PATTERN increments err_count (saturating).
// Without the macro err_count is tied to zero.
//
// Ports
//   clk        in   CLKDIV-rate clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   calibration request pulse (accepted in any state)
//   rx_data    in   [7:0] parallel word from the deserializer
//   bitslip    out  one-cycle slip request (registered)
//   aligned    out  calibration succeeded
//   fail       out  all slip positions exhausted
//   slip_count out  [2:0] slips issued in the current calibration
//   data_out   out  [7:0] rx_data delayed by one cycle
//   data_valid out  data_out qualified (equals aligned)
//   err_count  out  [15:0] post-alignment mismatch count
//
// Handshake: none; start is a level sampled every cycle, bitslip is a plain
// one-cycle pulse with no acknowledge from the deserializer.
// -----------------------------------------------------------------------------
module dq_rx_align
  import dq_rx_pkg::*;
#(
  parameter logic [DQ_W-1:0] TRAIN_PATTERN = 8'h0D,
  parameter int              SETTLE_CYCLES = 4,
  parameter int              MATCH_COUNT   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [DQ_W-1:0] rx_data,
  output logic            bitslip,
  output logic            aligned,
  output logic            fail,
  output logic [2:0]      slip_count,
  output logic [DQ_W-1:0] data_out,
  output logic            data_valid,
  output logic [15:0]     err_count
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] MATCH_LAST  = 8'(MATCH_COUNT - 1);

  align_state_e state_q, state_d;
  logic [3:0]   settle_q, settle_d;
  logic [7:0]   match_q, match_d;
  logic [2:0]   slip_q, slip_d;
  logic         bitslip_q, aligned_q, fail_q;
  logic [DQ_W-1:0] data_q;

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      settle_q <= '0;
      match_q  <= '0;
      slip_q   <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      match_q  <= match_d;
      slip_q   <= slip_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    match_d  = match_q;
    slip_d   = slip_q;
    if (start) begin
      // Restart from any state; a pulse already in flight in SLIP still
      // completes because bitslip is a register loaded on the previous edge.
      state_d  = SETTLE;
      settle_d = '0;
      match_d  = '0;
      slip_d   = '0;
    end else begin
      case (state_q)
        IDLE: ;
        SETTLE: begin
          if (settle_q == SETTLE_LAST) state_d = CHECK;
          else                         settle_d = settle_q + 4'd1;
        end
        CHECK: begin
          if (rx_data == TRAIN_PATTERN) begin
            if (match_q == MATCH_LAST) state_d = ALIGNED;
            else                       match_d = match_q + 8'd1;
          end else if (slip_q == 3'd7) begin
            state_d = FAIL;
          end else begin
            state_d = SLIP;
          end
        end
        SLIP: begin
          slip_d   = slip_q + 3'd1;
          settle_d = '0;
          match_d  = '0;
          state_d  = SETTLE;
        end
        ALIGNED: ;
        FAIL: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, loaded from the next state so they line up exactly
  // with the state they describe.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitslip_q <= 1'b0;
      aligned_q <= 1'b0;
      fail_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      bitslip_q <= (state_d == SLIP);
      aligned_q <= (state_d == ALIGNED);
      fail_q    <= (state_d == FAIL);
      data_q    <= rx_data;
    end
  end

  assign bitslip    = bitslip_q;
  assign aligned    = aligned_q;
  assign fail       = fail_q;
  assign data_valid = aligned_q;
  assign slip_count = slip_q;
  assign data_out   = data_q;

  // ---------------------------------------------------------------------------
  // Post-alignment error monitor
  // ---------------------------------------------------------------------------
`ifdef DQ_RX_ALIGN_ERRMON_EN
  logic [15:0] err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else if (start) begin
      err_q <= '0;
    end else if ((state_q == ALIGNED) && (rx_data != TRAIN_PATTERN) &&
                 (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule
